// File: rtl/mc_key_pkg.sv
// Shared constants and types for the MiniComputer key streamer.
// Optional build macro used by the top: MC_KEY_GAP_EN.
package mc_key_pkg;

    localparam int KEY_W = 128;

    localparam logic [7:0] ASCII_ETX   = 8'h03;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TERM = 2'd2
    } state_e;

endpackage

// File: rtl/mc_key_fifo.sv
// Small synchronous FIFO holding {last, byte} entries for the key streamer.
// The head entry is visible without a read cycle so a pop and its key decode share one edge.
module mc_key_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO refuses pushes even if it is being popped in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mc_key_streamer.sv
// Streams buffered ASCII program text onto the MiniComputer one-hot key lines, then holds etx.
// Build macro MC_KEY_GAP_EN inserts a forced all-zero cycle after every emitted key.
module mc_key_streamer
    import mc_key_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int KEY_W = mc_key_pkg::KEY_W
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     InValid,
    input  logic [7:0]               InData,
    input  logic                     InLast,
    output logic                     InReady,
    input  logic                     Go,
    output logic [KEY_W-1:0]         KeyVec,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Busy,
    output logic                     Done,
    output logic                     BadChar
);

    state_e             state_q;
    logic [KEY_W-1:0]   key_vec_q;
    logic               bad_char_q;
    logic               last_seen_q;
    logic               gap_hold;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [8:0]         fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_count;

    logic               head_last;
    logic [7:0]         head_data;
    logic [KEY_W-1:0]   char_vec;
    logic [KEY_W-1:0]   etx_vec;

`ifdef MC_KEY_GAP_EN
    logic               gap_q;
    assign gap_hold = gap_q;
`else
    assign gap_hold = 1'b0;
`endif

    assign InReady   = ~fifo_full & ~last_seen_q & (state_q != ST_TERM);
    assign fifo_push = InValid & InReady;
    assign fifo_pop  = (state_q == ST_RUN) & ~fifo_empty & ~gap_hold;

    assign head_last = fifo_rdata[8];
    assign head_data = fifo_rdata[7:0];

    mc_key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .push_i  (fifo_push),
        .wdata_i ({InLast, InData}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_dec
        assign char_vec[gi] = (head_data[6:0] == 7'(gi));
        assign etx_vec[gi]  = (gi == int'(ASCII_ETX));
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= ST_IDLE;
            key_vec_q   <= '0;
            bad_char_q  <= 1'b0;
            last_seen_q <= 1'b0;
`ifdef MC_KEY_GAP_EN
            gap_q       <= 1'b0;
`endif
        end else begin
            if (fifo_push && InLast) begin
                last_seen_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    key_vec_q <= '0;
                    if (Go) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fifo_pop) begin
                        // Bytes with bit 7 set have no key line; emit a blank cycle instead.
                        key_vec_q <= head_data[7] ? '0 : char_vec;
                        if (head_data[7]) begin
                            bad_char_q <= 1'b1;
                        end
                        if (head_last) begin
                            state_q <= ST_TERM;
                        end
`ifdef MC_KEY_GAP_EN
                        gap_q <= 1'b1;
`endif
                    end else begin
                        key_vec_q <= '0;
`ifdef MC_KEY_GAP_EN
                        gap_q <= 1'b0;
`endif
                    end
                end
                ST_TERM: begin
                    key_vec_q <= gap_hold ? '0 : etx_vec;
`ifdef MC_KEY_GAP_EN
                    gap_q <= 1'b0;
`endif
                end
                default: begin
                    state_q   <= ST_IDLE;
                    key_vec_q <= '0;
                end
            endcase
        end
    end

    assign KeyVec  = key_vec_q;
    assign Count   = fifo_count;
    assign Busy    = (state_q == ST_RUN);
    assign Done    = (state_q == ST_TERM);
    assign BadChar = bad_char_q;

endmodule
